debug_ram_writer_arb: RTL



---
 rtl/debug_ram_writer_arb.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/debug_ram_writer_arb.sv
// Round-robin write arbiter for debug RAM port A, with an optional full-RAM clear sweep.
// The clear engine is built only when DEBUG_RAM_CLEAR_EN is defined.
module debug_ram_writer_arb #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = {DATA_W{1'b0}}
) (
    input  logic                     clk50,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     clear_start,
    output logic                     clear_busy,
    output logic                     clear_done,
    output logic                     ram_en_a,
    output logic [ADDR_W-1:0]        ram_addr_a,
    output logic [DATA_W-1:0]        ram_data_a
);
    // Handshake: a requester holds valid/addr/data until its req_ready pulse;
    // the pulse coincides with the single ram_en_a cycle that performs its write.

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DEPTH = 1 << ADDR_W;

`ifdef DEBUG_RAM_CLEAR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, CLEAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1} state_t;
`endif

    state_t              state, state_n;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_n;
    logic [NREQ-1:0]     req_ready_n;
    logic                ram_en_n;
    logic [ADDR_W-1:0]   ram_addr_n;
    logic [DATA_W-1:0]   ram_data_n;
    logic                clear_busy_n, clear_done_n;
    logic                grant_found;
    logic [IDX_W-1:0]    grant_idx, cand;

`ifdef DEBUG_RAM_CLEAR_EN
    logic [ADDR_W:0]     clear_cnt, clear_cnt_n;
    logic                clear_pend, clear_pend_n;
`else
    logic                unused_clear;
    assign unused_clear = clear_start ^ (^CLEAR_VALUE);
`endif

    // First valid requester strictly after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_n      = state;
        rr_ptr_n     = rr_ptr;
        req_ready_n  = '0;
        ram_en_n     = 1'b0;
        ram_addr_n   = ram_addr_a;
        ram_data_n   = ram_data_a;
        clear_busy_n = clear_busy;
        clear_done_n = 1'b0;
`ifdef DEBUG_RAM_CLEAR_EN
        clear_cnt_n  = clear_cnt;
        clear_pend_n = clear_pend;
`endif
        case (state)
            IDLE: begin
`ifdef DEBUG_RAM_CLEAR_EN
                if (clear_pend || (clear_start && !clear_busy)) begin
                    state_n      = CLEAR;
                    clear_cnt_n  = '0;
                    clear_pend_n = 1'b0;
                    clear_busy_n = 1'b1;
                end else
`endif
                begin
                    clear_busy_n = 1'b0;
                    if (grant_found) begin
                        state_n                = WRITE;
                        rr_ptr_n               = grant_idx;
                        ram_en_n               = 1'b1;
                        ram_addr_n             = req_addr[grant_idx*ADDR_W +: ADDR_W];
                        ram_data_n             = req_data[grant_idx*DATA_W +: DATA_W];
                        req_ready_n[grant_idx] = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_n = IDLE;
`ifdef DEBUG_RAM_CLEAR_EN
                if (clear_start && !clear_busy) begin
                    clear_pend_n = 1'b1;
                    clear_busy_n = 1'b1;
                end
`endif
            end
`ifdef DEBUG_RAM_CLEAR_EN
            CLEAR: begin
                // clear_cnt reaching DEPTH means address DEPTH-1 is already on the port.
                if (clear_cnt == (ADDR_W+1)'(DEPTH)) begin
                    state_n      = IDLE;
                    clear_done_n = 1'b1;
                end else begin
                    ram_en_n    = 1'b1;
                    ram_addr_n  = clear_cnt[ADDR_W-1:0];
                    ram_data_n  = CLEAR_VALUE;
                    clear_cnt_n = clear_cnt + 1'b1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= IDX_W'(NREQ - 1);
            req_ready  <= '0;
            ram_en_a   <= 1'b0;
            ram_addr_a <= '0;
            ram_data_a <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
`ifdef DEBUG_RAM_CLEAR_EN
            clear_cnt  <= '0;
            clear_pend <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            rr_ptr     <= rr_ptr_n;
            req_ready  <= req_ready_n;
            ram_en_a   <= ram_en_n;
            ram_addr_a <= ram_addr_n;
            ram_data_a <= ram_data_n;
            clear_busy <= clear_busy_n;
            clear_done <= clear_done_n;
`ifdef DEBUG_RAM_CLEAR_EN
            clear_cnt  <= clear_cnt_n;
            clear_pend <= clear_pend_n;
`endif
        end
    end

endmodule
